// File: rtl/data_mem_if.sv
// ---------------------------------------------------------------------------
// data_mem_if
// Purpose : request/response bundle between the load/store queue (master)
//           and the data memory (slave).
// Signals :
//   req_valid  / req_ready   request handshake
//   req_write                1 = store commit, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_signed               load sign-extends when set
//   req_addr   [ADDR_W-1:0]  byte address
//   req_wdata  [31:0]        store data, low bytes used per size
//   req_pc     [31:0]        PC tag, echoed on the load response
//   flush                    kill all in-flight loads
//   rsp_valid  / rsp_ready   load response handshake
//   rsp_pc     [31:0]        PC tag of the returned load
//   rsp_data   [31:0]        extended load data
//   err                      one-cycle pulse on an accepted illegal size
// ---------------------------------------------------------------------------
interface data_mem_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_pc;
    logic [31:0]       rsp_data;
    logic              err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr,
               req_wdata, req_pc, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_pc, rsp_data, err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr,
               req_wdata, req_pc, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_pc, rsp_data, err
    );
endinterface

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// Purpose : byte-addressed, little-endian data memory behind the LSQ.
//           Stores commit in the cycle they are accepted. Loads travel
//           through a LAT-stage pipeline and read the array when they leave
//           the last stage, so every store accepted before that edge is
//           visible while a store on the very same edge is not.
// Params  : DEPTH  memory size in bytes (addresses wrap modulo DEPTH)
//           ADDR_W byte address width
//           LAT    load latency, acceptance to rsp_valid (1..4)
// Ports   : clk    single clock, rising edge
//           rstn   synchronous active-low reset; clears pipeline, response,
//                  err and every memory byte
//           bus    data_mem_if slave modport (request, flush, response, err)
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input logic       clk,
    input logic       rstn,
    data_mem_if.slave bus
);

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // One in-flight load: everything needed to read and format it later.
    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sgn;
    } stage_t;

    logic [7:0]  mem_q   [DEPTH];
    logic [7:0]  mem_d   [DEPTH];
    stage_t      stage_q [LAT];
    stage_t      stage_d [LAT];
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_pc_q,    rsp_pc_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    logic        err_q,       err_d;

    logic        stall;
    logic        accept;
    logic        illegal;
    logic        load_in;
    logic        store_in;
    stage_t      tail;
    logic [31:0] rd_raw;

    // Byte k of an access starting at base, wrapped into the array.
    function automatic logic [ADDR_W-1:0] byte_idx(input logic [ADDR_W-1:0] base,
                                                   input logic [2:0]        k);
        logic [31:0] sum;
        sum = (32'(base) + 32'(k)) % 32'(DEPTH);
        return ADDR_W'(sum);
    endfunction

    // Whether byte lane k takes part in an access of the given size.
    function automatic logic lane_used(input logic [1:0] size, input logic [2:0] k);
        logic used;
        case (size)
            SIZE_BYTE: used = (k == 3'd0);
            SIZE_HALF: used = (k <= 3'd1);
            SIZE_WORD: used = 1'b1;
            default:   used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = {{24{sgn & raw[7]}},  raw[7:0]};
            SIZE_HALF: res = {{16{sgn & raw[15]}}, raw[15:0]};
            default:   res = raw;
        endcase
        return res;
    endfunction

    assign tail = stage_q[LAT-1];

    // Handshake decode. A held response blocks everything behind it, so
    // nothing new may enter while it waits. A load arriving together with
    // flush is dropped on the floor; a store still commits because stores
    // are never speculative.
    always_comb begin
        stall    = rsp_valid_q & ~bus.rsp_ready;
        accept   = bus.req_valid & rstn & ~stall;
        illegal  = (bus.req_size == SIZE_ILLEGAL);
        load_in  = accept & ~bus.req_write & ~illegal & ~bus.flush;
        store_in = accept &  bus.req_write & ~illegal;
        err_d    = accept & illegal;
    end

    assign bus.req_ready = rstn & ~stall;

    // Raw little-endian word at the oldest load's address, taken from the
    // array as it stands before this edge's store lands.
    always_comb begin
        rd_raw = '0;
        for (int k = 0; k < 4; k++) begin
            rd_raw[8*k +: 8] = mem_q[byte_idx(tail.addr, 3'(k))];
        end
    end

    // Load pipeline and response register. Flush clears every valid bit
    // even while stalled; otherwise the whole pipe shifts by one whenever
    // the response slot is free or being consumed.
    always_comb begin
        stage_d     = stage_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_data_d  = rsp_data_q;
        if (bus.flush) begin
            for (int i = 0; i < LAT; i++) begin
                stage_d[i].valid = 1'b0;
            end
            rsp_valid_d = 1'b0;
        end else if (!stall) begin
            stage_d[0] = '{valid: load_in,
                           pc:    bus.req_pc,
                           addr:  bus.req_addr,
                           size:  bus.req_size,
                           sgn:   bus.req_signed};
            for (int i = 1; i < LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            rsp_valid_d = tail.valid;
            if (tail.valid) begin
                rsp_pc_d   = tail.pc;
                rsp_data_d = load_extend(rd_raw, tail.size, tail.sgn);
            end
        end
    end

    // Store commit: only the lanes covered by the access size are written.
    always_comb begin
        mem_d = mem_q;
        if (store_in) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_used(bus.req_size, 3'(k))) begin
                    mem_d[byte_idx(bus.req_addr, 3'(k))] = bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= 8'h00;
            end
        end else begin
            stage_q     <= stage_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_pc    = rsp_pc_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_data_mem.sv
// ---------------------------------------------------------------------------
// tb_data_mem
// Purpose : self-checking bench for data_mem. A behavioural model keeps a
//           byte array and a queue of outstanding loads, each aging by one
//           per unstalled cycle and answered when its age reaches LAT.
//           Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_data_mem;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic clk;
    logic rstn;

    data_mem_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int unsigned addr;
        logic [1:0]  size;
        logic        sgn;
        int          age;
    } pend_t;

    logic [7:0]  m_mem [DEPTH];
    pend_t       pend [$];
    logic        m_rsp_valid = 1'b0;
    logic [31:0] m_rsp_pc    = '0;
    logic [31:0] m_rsp_data  = '0;
    logic        m_err       = 1'b0;

    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_data;
    logic        obs_err;

    int checks_total  = 0;
    int checks_passed = 0;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Load value straight from the byte array: little-endian, wrapped, extended.
    function automatic logic [31:0] modelRead(input int unsigned addr, input logic [1:0] size,
                                              input logic sgn);
        int          n;
        logic [31:0] v;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        v = '0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(m_mem[(addr + k) % DEPTH]) << (8 * k));
        end
        if (n == 1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && sgn && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Reference behaviour for one rising edge, using the inputs the DUT saw.
    task automatic modelEdge();
        bit    stall;
        bit    acc;
        int    n;
        pend_t p;
        if (!rstn) begin
            for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
            pend.delete();
            m_rsp_valid = 1'b0;
            m_rsp_pc    = '0;
            m_rsp_data  = '0;
            m_err       = 1'b0;
            return;
        end
        stall = m_rsp_valid && !bus.rsp_ready;
        acc   = bus.req_valid && !stall;
        m_err = acc && (bus.req_size == 2'b11);
        if (bus.flush) begin
            pend.delete();
            m_rsp_valid = 1'b0;
        end else if (!stall) begin
            m_rsp_valid = 1'b0;
            foreach (pend[i]) pend[i].age++;
            if (pend.size() > 0 && pend[0].age == LAT) begin
                p           = pend.pop_front();
                m_rsp_valid = 1'b1;
                m_rsp_pc    = p.pc;
                m_rsp_data  = modelRead(p.addr, p.size, p.sgn);
            end
        end
        if (acc && !bus.req_write && bus.req_size != 2'b11 && !bus.flush) begin
            p.pc   = bus.req_pc;
            p.addr = int'(bus.req_addr);
            p.size = bus.req_size;
            p.sgn  = bus.req_signed;
            p.age  = 0;
            pend.push_back(p);
        end
        if (acc && bus.req_write && bus.req_size != 2'b11) begin
            n = (bus.req_size == 2'b00) ? 1 : (bus.req_size == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) begin
                m_mem[(int'(bus.req_addr) + k) % DEPTH] = bus.req_wdata[8*k +: 8];
            end
        end
    endtask

    // Drive one cycle of inputs, step one edge, then compare outputs.
    task automatic applyStimulus(input logic v, input logic w, input logic [1:0] size,
                                 input logic sgn, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc,
                                 input logic fl, input logic rr);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_pc     = pc;
        bus.flush      = fl;
        bus.rsp_ready  = rr;
        #1;
        checkOutput("req_ready", 32'(bus.req_ready), 32'(rstn && !(m_rsp_valid && !rr)));
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        obs_valid = bus.rsp_valid;
        obs_pc    = bus.rsp_pc;
        obs_data  = bus.rsp_data;
        obs_err   = bus.err;
        checkOutput("rsp_valid", 32'(obs_valid), 32'(m_rsp_valid));
        if (m_rsp_valid) begin
            checkOutput("rsp_pc",   obs_pc,   m_rsp_pc);
            checkOutput("rsp_data", obs_data, m_rsp_data);
        end
        checkOutput("err", 32'(obs_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic store(input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                         input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, size, 1'b0, addr, data, '0, 1'b0, 1'b1);
    endtask

    // Issue a single load and wait (bounded) for its response.
    task automatic loadWait(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [1:0] size, input logic sgn,
                            input logic [31:0] pc, input logic [31:0] exp);
        int n;
        applyStimulus(1'b1, 1'b0, size, sgn, addr, '0, pc, 1'b0, 1'b1);
        n = 0;
        while (!obs_valid && n < 8) begin
            idle(1);
            n++;
        end
        checkOutput({tag, "_lat"},  32'(n), 32'(LAT));
        checkOutput({tag, "_pc"},   obs_pc, pc);
        checkOutput({tag, "_data"}, obs_data, exp);
    endtask

    // Count responses seen over a window of idle cycles.
    task automatic countResponses(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            if (obs_valid) cnt++;
            idle(1);
        end
        if (obs_valid) cnt++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got [$];
        logic [31:0] exp_pcs [3];
        int          cnt;
        logic        v, w, sg, fl, rr;
        logic [1:0]  sz;
        int          r;

        $display("[TB] starting data_mem bench");
        obs_valid = 1'b0;
        obs_pc    = '0;
        obs_data  = '0;
        obs_err   = 1'b0;

        // Reset state
        rstn = 1'b0;
        idle(3);
        checkOutput("reset_rsp_pc",   obs_pc,   32'h0);
        checkOutput("reset_rsp_data", obs_data, 32'h0);
        rstn = 1'b1;
        idle(2);

        // Word store then word load, then sub-word extension
        store(10'h010, 2'b10, 32'h8765_4321);
        loadWait("lw_010",  10'h010, 2'b10, 1'b0, 32'h40, 32'h8765_4321);
        loadWait("lb_013",  10'h013, 2'b00, 1'b1, 32'h44, 32'hFFFF_FF87);
        loadWait("lbu_013", 10'h013, 2'b00, 1'b0, 32'h48, 32'h0000_0087);
        loadWait("lh_010",  10'h010, 2'b01, 1'b1, 32'h4C, 32'h0000_4321);
        loadWait("lhu_012", 10'h012, 2'b01, 1'b0, 32'h50, 32'h0000_8765);
        loadWait("lh_012",  10'h012, 2'b01, 1'b1, 32'h54, 32'hFFFF_8765);

        // Address wrap at the top of memory
        store(10'h3FE, 2'b10, 32'hAABB_CCDD);
        loadWait("lw_3fe",  10'h3FE, 2'b10, 1'b0, 32'h60, 32'hAABB_CCDD);
        loadWait("lbu_3ff", 10'h3FF, 2'b00, 1'b0, 32'h64, 32'h0000_00CC);
        loadWait("lbu_000", 10'h000, 2'b00, 1'b0, 32'h68, 32'h0000_00BB);
        loadWait("lbu_001", 10'h001, 2'b00, 1'b0, 32'h6C, 32'h0000_00AA);

        // Back-to-back loads with a three-cycle consumer stall
        idle(2);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, '0, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h3FE, '0, 32'h104, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h000, '0, 32'h108, 1'b0, 1'b0);
        repeat (3) begin
            applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, '0, 32'hDEAD, 1'b0, 1'b0);
            checkOutput("stall_hold_valid", 32'(obs_valid), 32'h1);
            checkOutput("stall_hold_pc",    obs_pc,   32'h100);
            checkOutput("stall_hold_data",  obs_data, 32'h8765_4321);
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (obs_valid) got.push_back(obs_pc);
            idle(1);
        end
        exp_pcs[0] = 32'h100;
        exp_pcs[1] = 32'h104;
        exp_pcs[2] = 32'h108;
        checkOutput("order_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("order_pc", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, exp_pcs[i]);
        end

        // Flush kills an in-flight load; the next load returns normally
        idle(2);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, '0, 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        countResponses(6, cnt);
        checkOutput("flush_no_rsp", 32'(cnt), 32'd0);
        loadWait("after_flush", 10'h010, 2'b10, 1'b0, 32'h204, 32'h8765_4321);

        // Store with flush commits, load with flush is dropped
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 10'h020, 32'h1122_3344, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, '0, 32'h300, 1'b1, 1'b1);
        countResponses(6, cnt);
        checkOutput("flush_load_dropped", 32'(cnt), 32'd0);
        loadWait("flush_store", 10'h020, 2'b10, 1'b0, 32'h304, 32'h1122_3344);

        // Illegal size: err pulse, no write, no response
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 10'h010, 32'hFFFF_FFFF, '0, 1'b0, 1'b1);
        checkOutput("err_pulse", 32'(obs_err), 32'h1);
        idle(1);
        checkOutput("err_clear", 32'(obs_err), 32'h0);
        loadWait("illegal_nowrite", 10'h010, 2'b10, 1'b0, 32'h400, 32'h8765_4321);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 10'h010, '0, 32'h404, 1'b0, 1'b1);
        checkOutput("err_pulse_load", 32'(obs_err), 32'h1);
        countResponses(6, cnt);
        checkOutput("illegal_no_rsp", 32'(cnt), 32'd0);

        // Reset in the middle of a load
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, '0, 32'h500, 1'b0, 1'b1);
        rstn = 1'b0;
        idle(2);
        checkOutput("rst_mid_valid", 32'(obs_valid), 32'h0);
        checkOutput("rst_mid_pc",    obs_pc,   32'h0);
        checkOutput("rst_mid_data",  obs_data, 32'h0);
        rstn = 1'b1;
        countResponses(4, cnt);
        checkOutput("rst_no_rsp", 32'(cnt), 32'd0);
        loadWait("rst_mem_010", 10'h010, 2'b10, 1'b0, 32'h504, 32'h0);
        loadWait("rst_mem_3fe", 10'h3FE, 2'b10, 1'b0, 32'h508, 32'h0);

        // Randomized traffic around the wrap point
        for (int c = 0; c < 400; c++) begin
            rstn = ($urandom_range(0, 99) != 0);
            v    = ($urandom_range(0, 9) < 7);
            w    = ($urandom_range(0, 9) < 3);
            r    = int'($urandom_range(0, 19));
            sz   = (r == 0) ? 2'b11 : 2'(r % 3);
            sg   = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 19) == 0);
            rr   = ($urandom_range(0, 3) != 0);
            applyStimulus(v, w, sz, sg, ADDR_W'(1016 + $urandom_range(0, 15)),
                          $urandom, $urandom, fl, rr);
        end
        rstn = 1'b1;
        idle(LAT + 2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in bytes; address wraps modulo DEPTH.
REQ-002 Parameter ADDR_W, default 10, byte-address width.
REQ-003 Parameter LAT, default 2, load latency in cycles from request acceptance to response valid; legal range 1..4.
REQ-004 Port clk input 1: single clock; all state updates on rising edge.
REQ-005 Port rstn input 1: reset, synchronous, active-low.
REQ-006 Port req_valid input 1: LSQ presents a memory request.
REQ-007 Port req_ready output 1: block can accept a request this cycle.
REQ-008 Port req_write input 1: 1 = store commit, 0 = load.
REQ-009 Port req_size input 2: 00 byte, 01 half, 10 word; 11 illegal.
REQ-010 Port req_signed input 1: load sign-extends when 1, zero-extends when 0.
REQ-011 Port req_addr input ADDR_W: byte address of request.
REQ-012 Port req_wdata input 32: store data, low bytes used per size.
REQ-013 Port req_pc input 32: PC tag of the instruction, returned with load response.
REQ-014 Port flush input 1: kill all in-flight loads (mis-speculation).
REQ-015 Port rsp_valid output 1: load response present.
REQ-016 Port rsp_ready input 1: LSQ accepts response.
REQ-017 Port rsp_pc output 32: PC tag of returned load.
REQ-018 Port rsp_data output 32: extended load data.
REQ-019 Port err output 1: one-cycle pulse when an illegal-size request is accepted.

Function
REQ-020 Request accepted when req_valid and req_ready both high at rising edge.
REQ-021 Storage SHALL be DEPTH x 8-bit array, little-endian: byte k of a multi-byte access at (req_addr+k) mod DEPTH.
REQ-022 Accepted store SHALL write 1/2/4 bytes in the acceptance cycle; no response generated.
REQ-023 Accepted load SHALL enter a LAT-stage pipeline carrying pc, addr, size, signed; data read at final stage so any store accepted in an earlier cycle is visible.
REQ-024 rsp_valid SHALL rise exactly LAT cycles after load acceptance when pipeline is not stalled.
REQ-025 Loads SHALL return in acceptance order; one response per load.
REQ-026 Stall: when rsp_valid=1 and rsp_ready=0, pipeline SHALL hold all stages and rsp_* stable; req_ready SHALL be 0.
REQ-027 req_ready SHALL be 1 when rstn=1 and no stall per REQ-026.
REQ-028 Back-to-back loads SHALL sustain one accepted load per cycle with rsp_ready held high.
REQ-029 Byte load: data[7:0]=mem byte, upper bits sign or zero; half: 16 bits extended; word: 32 bits as-is.
REQ-030 req_size=11 SHALL set err for one cycle, perform no write, and produce no response.
REQ-031 flush SHALL clear all pipeline stage valids and rsp_valid at the next edge; a request presented with flush is accepted only if it is a store (stores are committed, never speculative).
REQ-032 Simultaneous store and final-stage load on overlapping bytes: load SHALL return pre-store data (store written same edge).

Reset
REQ-033 While rstn=0 at an edge: all stage valids, rsp_valid, err cleared; rsp_pc, rsp_data = 0; all memory bytes = 0.
REQ-034 req_ready SHALL be 0 while rstn=0; reset mid-operation discards in-flight loads with no response.

Verification
REQ-035 Store word 0x8765_4321 at addr 0x010, then lw at 0x010 with pc 0x40 -> rsp_valid 2 cycles later, rsp_pc=0x40, rsp_data=0x8765_4321.
REQ-036 After REQ-035: lb signed at 0x013 -> 0xFFFF_FF87; lbu at 0x013 -> 0x0000_0087; lh signed at 0x010 -> 0x0000_4321.
REQ-037 Store word 0xAABB_CCDD at 0x3FE, lw at 0x3FE -> 0xAABB_CCDD; bytes landed at 0x3FE,0x3FF,0x000,0x001 (wrap).
REQ-038 Three back-to-back loads, rsp_ready=0 for 3 cycles after first response -> req_ready=0, rsp_* held, then three responses in order, none lost or duplicated.
REQ-039 Load accepted, flush asserted next cycle -> no rsp_valid ever for that load; next load returns normally.
REQ-040 Request size=11 -> err pulses one cycle, memory unchanged, no response; rstn low mid-load -> rsp_valid=0, memory reads 0.
